// File: rtl/vga_pkg.sv
// Shared types for the rect_fill drawing stage and the vga framebuffer write port.
package vga_pkg;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 3;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   coord_ext_t;   // one extra bit so x0+w cannot wrap
    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic [1:0] {
        IDLE,
        CLIP,
        FILL,
        DONE
    } rect_state_e;

    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t w;
        coord_t h;
        color_t color;
    } rect_cmd_t;

endpackage

// File: rtl/rect_clip.sv
// Combinational clipping of a fill rectangle against the active screen size.
module rect_clip
    import vga_pkg::*;
(
    input  rect_cmd_t  cmd_i,
    input  coord_t     width_i,
    input  coord_t     height_i,
    output coord_ext_t x_end_o,
    output coord_ext_t y_end_o,
    output logic       empty_o
);

    coord_ext_t x_sum;
    coord_ext_t y_sum;

    // Exclusive end coordinates = min(start + size, screen size); empty if nothing lands on screen.
    always_comb begin
        x_sum   = {1'b0, cmd_i.x0} + {1'b0, cmd_i.w};
        y_sum   = {1'b0, cmd_i.y0} + {1'b0, cmd_i.h};
        x_end_o = (x_sum < {1'b0, width_i})  ? x_sum : {1'b0, width_i};
        y_end_o = (y_sum < {1'b0, height_i}) ? y_sum : {1'b0, height_i};
        empty_o = (cmd_i.w == '0) || (cmd_i.h == '0) ||
                  (cmd_i.x0 >= width_i) || (cmd_i.y0 >= height_i);
    end

endmodule

// File: rtl/rect_fill.sv
// Rectangle-fill command engine: clips each command to the screen and emits one
// pixel write per cycle in raster order. Optional macro RECT_FILL_BLANK_WRITE_EN
// restricts writes to cycles where the vga 'visible' flag is low.
module rect_fill
    import vga_pkg::*;
(
    input  logic   clk,
    input  logic   arst_n,
    input  logic   cmd_valid,
    output logic   cmd_ready,
    input  coord_t cmd_x0,
    input  coord_t cmd_y0,
    input  coord_t cmd_w,
    input  coord_t cmd_h,
    input  color_t cmd_color,
    input  coord_t width,
    input  coord_t height,
    input  logic   visible,
    output coord_t X,
    output coord_t Y,
    output color_t pixel,
    output logic   wr_en,
    output logic   busy,
    output logic   done
);

    rect_state_e state_q, state_d;
    rect_cmd_t   cmd_q;
    coord_ext_t  x_end_q, y_end_q;
    coord_t      cur_x_q, cur_x_d;
    coord_t      cur_y_q, cur_y_d;

    coord_ext_t  x_end_c, y_end_c;
    logic        empty_c;
    logic        gate;
    logic        x_last, y_last;

`ifdef RECT_FILL_BLANK_WRITE_EN
    assign gate = ~visible;
`else
    logic unused_visible;
    assign unused_visible = visible;
    assign gate           = 1'b1;
`endif

    rect_clip u_clip (
        .cmd_i    (cmd_q),
        .width_i  (width),
        .height_i (height),
        .x_end_o  (x_end_c),
        .y_end_o  (y_end_c),
        .empty_o  (empty_c)
    );

    assign x_last = ({1'b0, cur_x_q} + coord_ext_t'(1)) == x_end_q;
    assign y_last = ({1'b0, cur_y_q} + coord_ext_t'(1)) == y_end_q;

    // Ready only in IDLE and forced low while reset is held.
    assign cmd_ready = (state_q == IDLE) && arst_n;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign X         = (state_q == FILL) ? cur_x_q   : '0;
    assign Y         = (state_q == FILL) ? cur_y_q   : '0;
    assign pixel     = (state_q == FILL) ? cmd_q.color : '0;

    // Next-state, raster cursor advance and write strobe.
    always_comb begin
        state_d = state_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) state_d = CLIP;
            end
            CLIP: begin
                cur_x_d = cmd_q.x0;
                cur_y_d = cmd_q.y0;
                state_d = empty_c ? DONE : FILL;
            end
            FILL: begin
                if (gate) begin
                    wr_en = 1'b1;
                    if (x_last) begin
                        cur_x_d = cmd_q.x0;
                        cur_y_d = cur_y_q + coord_t'(1);
                        if (y_last) state_d = DONE;
                    end else begin
                        cur_x_d = cur_x_q + coord_t'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register; reset aborts any fill in progress.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Datapath registers: command latch, clip results and raster cursor.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && cmd_valid) begin
            cmd_q <= '{x0: cmd_x0, y0: cmd_y0, w: cmd_w, h: cmd_h, color: cmd_color};
        end
        if (state_q == CLIP) begin
            x_end_q <= x_end_c;
            y_end_q <= y_end_c;
        end
        cur_x_q <= cur_x_d;
        cur_y_q <= cur_y_d;
    end

endmodule

// File: tb/tb_rect_fill.sv
// Bench for rect_fill: table of directed commands, randomized commands against a
// raster-list reference model, and hand-written back-to-back and reset sequences.
module tb_rect_fill;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_x0, cmd_y0, cmd_w, cmd_h;
    logic [2:0] cmd_color;
    logic [9:0] width, height;
    logic       visible;
    logic [9:0] X, Y;
    logic [2:0] pixel;
    logic       wr_en, busy, done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rect_fill dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .width     (width),
        .height    (height),
        .visible   (visible),
        .X         (X),
        .Y         (Y),
        .pixel     (pixel),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int x0, y0, w, h, color, wd, ht;
        int exp_n;   // expected number of pixel writes
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) until the DUT is ready at a falling edge.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ready_timeout", 0, 1);
    endtask

    // Issue one command and check every cycle up to done against the reference list.
    task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                           input int color, input int wd, input int ht,
                           input int exp_n, input logic [31:0] vmask);
        int qx[$];
        int qy[$];
        int xe, ye, n, idx, done_cycle, dut_wr;
        bit ok, finished, gate, exp_wr;

        // Reference: every on-screen pixel of the rectangle in raster order.
        xe = (x0 + w < wd) ? x0 + w : wd;
        ye = (y0 + h < ht) ? y0 + h : ht;
        if (w != 0 && h != 0 && x0 < wd && y0 < ht)
            for (int yy = y0; yy < ye; yy++)
                for (int xx = x0; xx < xe; xx++) begin
                    qx.push_back(xx);
                    qy.push_back(yy);
                end
        n          = qx.size();
        done_cycle = (n == 0) ? 2 : 1 << 30;
        idx        = 0;
        dut_wr     = 0;
        finished   = 1'b0;

        wait_ready(ok);
        if (!ok) return;
        cmd_valid = 1'b1;
        cmd_x0    = 10'(x0);
        cmd_y0    = 10'(y0);
        cmd_w     = 10'(w);
        cmd_h     = 10'(h);
        cmd_color = 3'(color);
        width     = 10'(wd);
        height    = 10'(ht);

        for (int i = 1; i <= n + 60 && !finished; i++) begin
            @(posedge clk);
            #1;
`ifdef RECT_FILL_BLANK_WRITE_EN
            visible = (i < 32) ? vmask[i] : 1'b0;
`else
            visible = 1'($urandom_range(0, 1));
`endif
            if (i == 1) begin
                cmd_valid = 1'b0;
                cmd_x0 = 10'($urandom); cmd_y0 = 10'($urandom);
                cmd_w  = 10'($urandom); cmd_h  = 10'($urandom);
                cmd_color = 3'($urandom);
            end
            if (i == 2) begin
                width  = 10'($urandom);
                height = 10'($urandom);
            end
            @(negedge clk);
`ifdef RECT_FILL_BLANK_WRITE_EN
            gate = !visible;
`else
            gate = 1'b1;
`endif
            exp_wr = (i >= 2) && (idx < n) && gate;
            chk("wr_en", int'(wr_en), int'(exp_wr));
            chk("cmd_ready_busy", int'(cmd_ready), 0);
            if (wr_en) dut_wr++;
            if (wr_en && idx < n) begin
                chk("X", int'(X), qx[idx]);
                chk("Y", int'(Y), qy[idx]);
                chk("pixel", int'(pixel), color);
            end
            if (exp_wr) begin
                idx++;
                if (idx == n) done_cycle = i + 1;
            end
            chk("done", int'(done), int'(i == done_cycle));
            chk("busy", int'(busy), 1);
            if (i == done_cycle) begin
                chk("X_idle", int'(X), 0);
                chk("Y_idle", int'(Y), 0);
                finished = 1'b1;
            end
        end
        if (!finished) chk("done_timeout", 0, 1);
        chk("write_count", dut_wr, (exp_n >= 0) ? exp_n : n);
        @(negedge clk);
        chk("ready_after_done", int'(cmd_ready), 1);
        chk("busy_after_done", int'(busy), 0);
        visible = 1'b0;
    endtask

    initial begin
        bit ok;
        int wr_seen;
        int exp_wr_c[8];
        int exp_done_c[8];
        int exp_rdy_c[8];

        tbl[0] = '{x0: 2,    y0: 3,    w: 3,    h: 2,    color: 5, wd: 640,  ht: 480,  exp_n: 6};
        tbl[1] = '{x0: 638,  y0: 479,  w: 5,    h: 4,    color: 3, wd: 640,  ht: 480,  exp_n: 2};
        tbl[2] = '{x0: 10,   y0: 10,   w: 0,    h: 5,    color: 1, wd: 640,  ht: 480,  exp_n: 0};
        tbl[3] = '{x0: 700,  y0: 10,   w: 5,    h: 5,    color: 2, wd: 640,  ht: 480,  exp_n: 0};
        tbl[4] = '{x0: 4,    y0: 4,    w: 3,    h: 0,    color: 4, wd: 640,  ht: 480,  exp_n: 0};
        tbl[5] = '{x0: 0,    y0: 480,  w: 3,    h: 3,    color: 6, wd: 640,  ht: 480,  exp_n: 0};
        tbl[6] = '{x0: 0,    y0: 0,    w: 1,    h: 1,    color: 7, wd: 640,  ht: 480,  exp_n: 1};
        tbl[7] = '{x0: 0,    y0: 0,    w: 4,    h: 3,    color: 1, wd: 2,    ht: 2,    exp_n: 4};
        tbl[8] = '{x0: 1020, y0: 1022, w: 1023, h: 1023, color: 5, wd: 1023, ht: 1023, exp_n: 3};
        tbl[9] = '{x0: 0,    y0: 0,    w: 1023, h: 1,    color: 2, wd: 8,    ht: 480,  exp_n: 8};

        arst_n = 1'b0; cmd_valid = 1'b0; visible = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        width = 10'd640; height = 10'd480;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_X", int'(X), 0);
        chk("rst_Y", int'(Y), 0);
        chk("rst_pixel", int'(pixel), 0);
        arst_n = 1'b1;
        #1;
        chk("rel_cmd_ready", int'(cmd_ready), 1);

        // Directed table
        for (int v = 0; v < 10; v++)
            run_cmd(tbl[v].x0, tbl[v].y0, tbl[v].w, tbl[v].h, tbl[v].color,
                    tbl[v].wd, tbl[v].ht, tbl[v].exp_n, 32'h0);

        // Randomized commands against the reference list
        for (int r = 0; r < 40; r++) begin
            if (r % 8 == 0)
                run_cmd(int'($urandom_range(630, 660)), int'($urandom_range(470, 490)),
                        int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                        int'($urandom_range(0, 7)), 640, 480, -1, 32'h0);
            else
                run_cmd(int'($urandom_range(0, 45)), int'($urandom_range(0, 35)),
                        int'($urandom_range(0, 12)), int'($urandom_range(0, 8)),
                        int'($urandom_range(0, 7)), int'($urandom_range(1, 40)),
                        int'($urandom_range(1, 30)), -1, 32'h0);
        end

        // Back-to-back: valid held high across two 1x1 commands
        exp_wr_c   = '{0, 1, 0, 0, 0, 1, 0, 0};
        exp_done_c = '{0, 0, 1, 0, 0, 0, 1, 0};
        exp_rdy_c  = '{0, 0, 0, 1, 0, 0, 0, 1};
        wait_ready(ok);
        cmd_valid = 1'b1; cmd_x0 = 10'd5; cmd_y0 = 10'd6; cmd_w = 10'd1; cmd_h = 10'd1;
        cmd_color = 3'd2; width = 10'd640; height = 10'd480;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                cmd_x0 = 10'd7; cmd_y0 = 10'd9; cmd_color = 3'd6;
            end
            if (c == 5) cmd_valid = 1'b0;
            @(negedge clk);
            chk("b2b_wr_en", int'(wr_en), exp_wr_c[c-1]);
            chk("b2b_done", int'(done), exp_done_c[c-1]);
            chk("b2b_ready", int'(cmd_ready), exp_rdy_c[c-1]);
            if (c == 2) begin
                chk("b2b_X_a", int'(X), 5); chk("b2b_Y_a", int'(Y), 6); chk("b2b_pix_a", int'(pixel), 2);
            end
            if (c == 6) begin
                chk("b2b_X_b", int'(X), 7); chk("b2b_Y_b", int'(Y), 9); chk("b2b_pix_b", int'(pixel), 6);
            end
        end

        // Reset asserted mid-fill of a 10x10 rectangle
        wait_ready(ok);
        cmd_valid = 1'b1; cmd_x0 = 10'd20; cmd_y0 = 10'd20; cmd_w = 10'd10; cmd_h = 10'd10;
        cmd_color = 3'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("midfill_wr_en", int'(wr_en), 1);
        arst_n = 1'b0;
        #1;
        chk("abort_wr_en", int'(wr_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ready", int'(cmd_ready), 0);
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        chk("abort_rel_ready", int'(cmd_ready), 1);
        wr_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (wr_en || done) wr_seen++;
        end
        chk("abort_quiet", wr_seen, 0);
        run_cmd(1, 1, 1, 1, 4, 640, 480, 1, 32'h0);

`ifdef RECT_FILL_BLANK_WRITE_EN
        // 4x1 fill with visible high for cycles 2..4 after the handshake
        run_cmd(10, 10, 4, 1, 5, 640, 480, 4, 32'h0000_001C);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rect_fill.md
# rect_fill

Upstream drawing stage for the `vga` framebuffer controller. Accepts rectangle-fill commands over a valid/ready handshake, clips each rectangle to the active screen size, and emits one pixel write per cycle in raster order on the `X`/`Y`/`pixel`/`wr_en` write port of `vga`. Optionally holds writes to blanking intervals so frames do not tear.

## Interface
- `COORD_W`, 10, width of all coordinate and size fields; matches the `vga` address width.
- `COLOR_W`, 3, pixel colour width; matches the `vga` pixel width.

- `clk`  in  1  system clock; the same clock as the `vga` write port.
- `arst_n`  in  1  reset, asynchronous assert, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_x0`, `cmd_y0`  in  COORD_W  top-left corner.
- `cmd_w`, `cmd_h`  in  COORD_W  rectangle size in pixels; 0 means empty.
- `cmd_color`  in  COLOR_W  fill colour.
- `width`, `height`  in  COORD_W  active screen size, sampled in CLIP.
- `visible`  in  1  `vga` visible flag, synchronous to `clk`; used only with the macro.
- `X`, `Y`  out  COORD_W  write address.
- `pixel`  out  COLOR_W  write data.
- `wr_en`  out  1  write strobe.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a command completes, including empty commands.

## Operation
- FSM states: IDLE, CLIP, FILL, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch the `cmd_*` fields and go to CLIP.
- CLIP (1 cycle): compute `x_end = min(x0+w, width)` and `y_end = min(y0+h, height)` in COORD_W+1 bits, so sums cannot overflow.
  - Empty if `w==0`, `h==0`, `x0>=width` or `y0>=height` → go to DONE with no writes.
  - Otherwise set `cur_x=x0`, `cur_y=y0` and go to FILL.
- FILL: each enabled cycle presents `X=cur_x`, `Y=cur_y`, `pixel=color`, `wr_en=1`, then advances.
  - `cur_x==x_end-1`: wrap `cur_x` to `x0` and increment `cur_y`.
  - Last pixel (`cur_x==x_end-1 && cur_y==y_end-1`): go to DONE.
- DONE (1 cycle): `done`=1, then go to IDLE.
- `width`, `height` and `cmd_*` changes after the handshake are ignored until the next command.
- `X`, `Y` and `pixel` are don't-care when `wr_en`=0, but are driven to 0 outside FILL.
- Reset values: `cmd_ready`=0 while `arst_n` is low and 1 after release; `wr_en`, `busy`, `done` = 0; `X`, `Y`, `pixel` = 0; state = IDLE.
- Reset asserted mid-FILL aborts the command immediately. No further writes occur and `done` does not pulse.

## Timing
- Handshake at edge k → CLIP during cycle k+1 → first `wr_en` during cycle k+2.
- Ungated throughput is 1 pixel/clk. N pixels occupy cycles k+2 … k+N+1, and `done` is high in cycle k+N+2.
- Empty command: `done` is high in cycle k+2 with no `wr_en`.
- Next command accept is no earlier than 1 cycle after `done`, because `cmd_ready` returns with IDLE.
- `wr_en` is combinational from state and gate. `X`, `Y` and `pixel` come from registers. No combinational path exists from `cmd_*` to the outputs.

## Configuration
- `RECT_FILL_BLANK_WRITE_EN` defined: in FILL, `wr_en = !visible`. When `visible`=1 the FSM holds and `cur_x`/`cur_y` do not advance, which stretches latency by the number of stalled cycles.
- Undefined: `visible` is ignored and writes proceed every FILL cycle.

## Structure
- Package `vga_pkg`:
  - `COORD_W`, `COLOR_W` constants.
  - `coord_t`, `color_t` typedefs.
  - `rect_state_e` enum {IDLE, CLIP, FILL, DONE}.
  - `rect_cmd_t` struct {x0, y0, w, h, color}.
- Sub-module `rect_clip`: pure combinational computation of `x_end`, `y_end` and `empty` from the command and screen size. It is instantiated once and its results are registered in CLIP.

## Test plan
- x0=2, y0=3, w=3, h=2, colour 5, screen 640×480 → 6 writes: (2,3) (3,3) (4,3) (2,4) (3,4) (4,4), all pixel=5. First `wr_en` 2 cycles after handshake; `done` 1 cycle after the last write.
- x0=638, y0=479, w=5, h=4, screen 640×480 → clipped to 2 writes: (638,479) (639,479), then `done`.
- w=0 or x0=700 → no `wr_en`, `done` 2 cycles after handshake, `cmd_ready` back 1 cycle later.
- Back-to-back `cmd_valid` held high with two 1×1 commands → second accepted the cycle after the first `done`; writes never overlap.
- `arst_n` pulsed low mid-FILL of a 10×10 fill → `wr_en`, `busy`, `done` = 0 immediately; after release `cmd_ready`=1 and a new 1×1 command completes normally.
- With `RECT_FILL_BLANK_WRITE_EN`, 4×1 fill with `visible` high for cycles 2–4 → writes only in non-visible cycles, all 4 addresses still written in order, `done` delayed 3 cycles.
